// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter in front of a single UART transmitter.
// One requester is granted while the line is idle. Its byte is latched in
// the grant cycle and sent as start bit, DATA_BITS payload bits (LSB first)
// and a stop bit, each lasting CLKS_PER_BIT clocks.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]   data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [$clog2(NUM_REQ)-1:0]     owner,
  output logic                           busy,
  output logic                           tx
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

  logic [1:0]           state_q,   state_d;
  logic [CNT_W-1:0]     baud_q,    baud_d;
  logic [BIT_W-1:0]     bit_q,     bit_d;
  logic [IDX_W-1:0]     ptr_q,     ptr_d;
  logic [IDX_W-1:0]     owner_q,   owner_d;
  logic [DATA_BITS-1:0] payload_q, payload_d;
  logic                 tx_q,      tx_d;

  logic                 win_any;
  logic [IDX_W-1:0]     win_idx;
  logic [DATA_BITS-1:0] win_data;
  logic                 baud_wrap;

  assign baud_wrap = (baud_q == BAUD_LAST);

  // Round-robin search: start at ptr_q, wrap modulo NUM_REQ, first set req wins.
  always_comb begin
    int j;
    // NOTE: every variable written here gets a default before any branch so
    // no path leaves it unassigned, which would otherwise infer a latch.
    j        = 0;
    win_any  = 1'b0;
    win_idx  = '0;
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_any && req[j]) begin
        win_any  = 1'b1;
        win_idx  = IDX_W'(j);
        win_data = data[j*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Frame sequencer: grant in IDLE, then time START, DATA bits and STOP.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    payload_d = payload_q;
    gnt       = '0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (win_any) begin
          gnt[win_idx] = 1'b1;
          owner_d      = win_idx;
          payload_d    = win_data;
          ptr_d        = (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
          state_d      = S_START;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A grant would be discarded by the reset edge, so never show one.
    if (rst) gnt = '0;
  end

  // Line level for the coming cycle, derived from the next state so tx is
  // registered yet aligned with the state it belongs to.
  always_comb begin
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = payload_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Control state with synchronous active-high reset; reset aborts any frame.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking writes here would race readers.
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      tx_q    <= tx_d;
    end
  end

  // Payload holding register, loaded only in a grant cycle.
  always_ff @(posedge clk) begin
    // NOTE: payload is deliberately not reset; it is always written by a
    // grant before tx ever reads it, so a reset would only cost routing.
    payload_q <= payload_d;
  end

  assign owner = owner_q;
  assign busy  = (state_q != S_IDLE);
  assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, CLKS_PER_BIT=16, DATA_BITS=8).
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic        tx;

  int n_cmp = 0;
  int n_mis = 0;

  uart_tx_arbiter #(
    .NUM_REQ(4), .CLKS_PER_BIT(16), .DATA_BITS(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .gnt(gnt), .owner(owner), .busy(busy), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled 2-3 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", name, obs, exp);
    end
  endtask

  // Waits (bounded) for a grant, checks it, then follows the whole 160-cycle
  // frame and ends in the following IDLE cycle. Up to two input changes
  // (req and data) are applied at frame cycles at_a / at_b (-1 = none).
  task automatic run_frame(input string tag, input logic [3:0] exp_gnt,
                           input logic [7:0] exp_byte, input logic [1:0] exp_owner,
                           input int at_a, input logic [3:0] req_a, input logic [31:0] dat_a,
                           input int at_b, input logic [3:0] req_b, input logic [31:0] dat_b,
                           output int waited);
    int         shape_err, busy_cnt, extra_gnt;
    logic [7:0] dec;
    logic [2:0] bi;
    logic       exp_tx;
    logic       seen;
    waited    = 0;
    seen      = 1'b0;
    shape_err = 0;
    busy_cnt  = 0;
    extra_gnt = 0;
    dec       = '0;
    for (int w = 0; w < 40; w++) begin
      #1;
      if (gnt !== 4'b0000) begin
        seen = 1'b1;
        break;
      end
      tick();
      waited++;
    end
    check({tag, ".grant_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    tick();
    for (int c = 0; c < 160; c++) begin
      if (c == at_a) begin req = req_a; data = dat_a; end
      if (c == at_b) begin req = req_b; data = dat_b; end
      #1;
      bi = 3'((c - 16) / 16);
      if (c < 16)       exp_tx = 1'b0;
      else if (c < 144) exp_tx = exp_byte[bi];
      else              exp_tx = 1'b1;
      if (tx !== exp_tx) shape_err++;
      if (busy === 1'b1) busy_cnt++;
      if (gnt !== 4'b0000) extra_gnt++;
      if (c >= 16 && c < 144 && ((c - 16) % 16) == 8) dec[bi] = tx;
      tick();
    end
    #1;
    check({tag, ".tx_shape_errors"}, 32'(shape_err), 32'd0);
    check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd160);
    check({tag, ".gnt_during_frame"}, 32'(extra_gnt), 32'd0);
    check({tag, ".byte"}, 32'(dec), 32'(exp_byte));
    check({tag, ".owner"}, 32'(owner), 32'(exp_owner));
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".idle_tx"}, 32'(tx), 32'd1);
  endtask

  initial begin
    logic [7:0] rr_bytes [4];
    int         waited;
    int         bad;
    logic       seen;

    rr_bytes[0] = 8'h11;
    rr_bytes[1] = 8'h22;
    rr_bytes[2] = 8'h33;
    rr_bytes[3] = 8'h44;

    // Reset with all requests high: no grant may leak out.
    rst  = 1'b1;
    req  = 4'b1111;
    data = 32'h4433_2211;
    tick();
    tick();
    #1;
    check("reset.gnt", 32'(gnt), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.tx", 32'(tx), 32'd1);
    check("reset.owner", 32'(owner), 32'd0);
    check("reset.ptr", 32'(dut.ptr_q), 32'd0);
    req = 4'b0000;
    rst = 1'b0;
    tick();

    // Single requester 0 sending 0xA5.
    data = 32'h4433_22A5;
    req  = 4'b0001;
    run_frame("single", 4'b0001, 8'hA5, 2'd0, 0, 4'b0000, 32'h4433_22A5,
              -1, 4'b0000, 32'h0, waited);

    // Fresh reset, then all four held: order 0,1,2,3,0 with one idle cycle.
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    req  = 4'b1111;
    data = 32'h4433_2211;
    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("rr%0d", i), 4'b0001 << (i % 4), rr_bytes[i % 4], 2'(i % 4),
                (i == 4) ? 0 : -1, 4'b0000, 32'h4433_2211,
                -1, 4'b0000, 32'h0, waited);
      check($sformatf("rr%0d.idle_gap", i), 32'(waited), 32'd0);
    end

    // req[2] rises mid-frame and falls during STOP: never granted.
    data = 32'h4433_2211;
    req  = 4'b0001;
    run_frame("late_req", 4'b0001, 8'h11, 2'd0, 30, 4'b0100, 32'h4433_2211,
              150, 4'b0000, 32'h4433_2211, waited);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      #1;
      if (tx !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b0) bad++;
    end
    check("late_req.quiet_after", 32'(bad), 32'd0);

    // data0 changes to 0xFF one cycle after the grant: frame still 0x3C.
    data = 32'h4433_223C;
    req  = 4'b0001;
    run_frame("data_change", 4'b0001, 8'h3C, 2'd0, 0, 4'b0000, 32'h4433_22FF,
              -1, 4'b0000, 32'h0, waited);

    // Requester 2 frame aborted by reset at cycle 50; afterwards with
    // req=1010 held, requester 1 wins because the pointer is back at 0.
    data = 32'h445A_2211;
    req  = 4'b0100;
    seen = 1'b0;
    for (int w = 0; w < 40; w++) begin
      #1;
      if (gnt !== 4'b0000) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("abort.grant_seen", 32'(seen), 32'd1);
    check("abort.gnt", 32'(gnt), 32'b0100);
    tick();
    req = 4'b1010;
    repeat (50) tick();
    #1;
    check("abort.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort.tx", 32'(tx), 32'd1);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.ptr", 32'(dut.ptr_q), 32'd0);
    check("abort.owner", 32'(owner), 32'd0);
    check("abort.first_gnt", 32'(gnt), 32'b0010);
    run_frame("post_abort", 4'b0010, 8'h22, 2'd1, 0, 4'b0000, 32'h445A_2211,
              -1, 4'b0000, 32'h0, waited);
    check("post_abort.wait", 32'(waited), 32'd0);

    // Owner 0 holds req while req[3] rises mid-frame: 3 is served before 0 again.
    data = 32'h4433_2211;
    req  = 4'b0001;
    run_frame("hold0", 4'b0001, 8'h11, 2'd0, 40, 4'b1001, 32'h4433_2211,
              -1, 4'b0000, 32'h0, waited);
    run_frame("then3", 4'b1000, 8'h44, 2'd3, -1, 4'b0000, 32'h0,
              -1, 4'b0000, 32'h0, waited);
    check("then3.idle_gap", 32'(waited), 32'd0);
    run_frame("then0", 4'b0001, 8'h11, 2'd0, 0, 4'b0000, 32'h4433_2211,
              -1, 4'b0000, 32'h0, waited);
    check("then0.idle_gap", 32'(waited), 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
